mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
- Sequencing and arbitration controller for the shared 32x32 multiplier datapath, built from one MULT32 (signed) and one MULT32_U (unsigned) instance.
- Two requesters share one multiplier. A round-robin arbiter selects one, latches its operands and holds them stable for a settle window. It then captures the 64-bit product into HI/LO and signals completion to the owning requester.
- Sits between the execute stage and any auxiliary requester, such as an address-scaling or debug port.

Parameters:
- DATA_WIDTH, 32, operand width; HI and LO are each DATA_WIDTH wide.
- SETTLE_CYCLES, 2, clock edges the latched operands are held before capture; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- REQ0  input  1  requester 0 request level.
- SIGNED0  input  1  requester 0: 1 = signed (MULT32), 0 = unsigned (MULT32_U).
- A0  input  DATA_WIDTH  requester 0 multiplicand.
- B0  input  DATA_WIDTH  requester 0 multiplier.
- REQ1, SIGNED1, A1, B1  input  1/1/DATA_WIDTH/DATA_WIDTH  requester 1, same meaning as requester 0.
- GNT0  output  1  one-cycle pulse: requester 0 operands accepted.
- GNT1  output  1  one-cycle pulse: requester 1 operands accepted.
- DONE0  output  1  one-cycle pulse: HI/LO holds requester 0 result.
- DONE1  output  1  one-cycle pulse: HI/LO holds requester 1 result.
- HI  output  DATA_WIDTH  registered upper product word.
- LO  output  DATA_WIDTH  registered lower product word.
- BUSY  output  1  high while an operation is in flight (state RUN).

Behaviour:
- Reset (RST low, asynchronous):
  - state=IDLE, priority pointer PRI=0, counter=0, latched operands=0.
  - GNT0/1=0, DONE0/1=0, HI=LO=0, BUSY=0.
  - Any in-flight operation is discarded; no DONE is issued for it.
- State machine, two states:
  - IDLE: at a rising edge with REQ0 or REQ1 high, the arbiter selects the owner.
    - Only one request high: that requester wins.
    - Both high: requester PRI wins.
    - The edge latches the owner's A, B, SIGNED and owner id, loads counter=SETTLE_CYCLES-1, sets state=RUN, and sets PRI to the non-winning index.
    - GNT of the winner is high for exactly the following cycle. BUSY is high from that cycle on.
  - RUN: each edge with counter!=0 decrements the counter. The edge with counter==0 does the following:
    - loads {HI,LO} from the selected multiplier output (MULT32 if latched SIGNED=1, else MULT32_U);
    - pulses the owner's DONE for the following cycle;
    - sets state=IDLE and BUSY=0 in that same cycle.
  - REQ/A/B/SIGNED inputs are ignored in RUN.
- Timing:
  - Latency: accept edge E; capture and DONE-valid at edge E+SETTLE_CYCLES.
  - A new request can be accepted at edge E+SETTLE_CYCLES+1, the edge ending the DONE cycle.
  - Maximum throughput is one operation per SETTLE_CYCLES+1 cycles.
- Handshake rules:
  - A requester holds REQ and operands stable until it sees GNT. It then drops REQ, or keeps it high to issue a new request.
  - REQ still high when the scheduler returns to IDLE is treated as a new request.
  - GNT and DONE of the same requester never assert in the same cycle, since SETTLE_CYCLES>=1.
- Arithmetic:
  - Full 64-bit product, no truncation or overflow flag.
  - Signed mode uses two's-complement operands; the result is sign-correct across all 64 bits.
- HI/LO hold their last captured value indefinitely. Only a capture or reset changes them.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1...

Test Plan:
- Reset check: hold RST low, toggle CLK -> GNT0/1=0, DONE0/1=0, BUSY=0, HI=LO=0. Release RST, no REQ -> outputs unchanged.
- Single unsigned op, SETTLE_CYCLES=2: REQ0=1, SIGNED0=0, A0=10, B0=20 at edge E -> GNT0 high in cycle E..E+1, BUSY high. DONE0 high after edge E+2 with {HI,LO}=0x00000000_000000C8.
- Simultaneous requests after reset:
  - REQ0 signed A0=-3, B0=-15; REQ1 signed A1=0x90000000, B1=0x70000000.
  - Requester 0 served first -> {HI,LO}=0x00000000_0000002D.
  - Then requester 1: GNT1 at edge E+3, DONE1 three cycles after DONE0 -> {HI,LO}=0xCF000000_00000000.
- Signed vs unsigned on the same operands, A=0x90000000, B=0x70000000:
  - unsigned -> 0x3F000000_00000000;
  - signed -> 0xCF000000_00000000;
  - A=B=0x70000000 in either mode -> 0x31000000_00000000.
- Reset mid-RUN: assert RST low one cycle after GNT0 -> BUSY=0, no DONE0, HI=LO=0. The next REQ1 (A1=3, B1=15, unsigned) completes normally with 0x2D and GNT1 (PRI reset to 0, only REQ1 pending).
- Fairness and back-to-back: hold REQ0 and REQ1 high continuously for 12 cycles -> grants alternate 0,1,0,1 every 3 cycles, DONE order matches grant order, and no cycle has both GNT0 and GNT1 high.

Source files
------------

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module  : mult_sched
// Purpose : Two-requester round-robin scheduler for a shared 32x32 multiplier;
//           latches operands, holds them for a settle window, captures HI/LO.
// Revision: 1.0
// ============================================================================
module mult_sched #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  SIGNED0,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic                  REQ1,
  input  logic                  SIGNED1,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    pri_q, pri_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    sgn_q, sgn_d;
  logic                    owner_q, owner_d;
  logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                    done0_q, done0_d, done1_q, done1_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                    w_win1;
  logic [2*DATA_WIDTH-1:0] w_prod_u, w_prod_s;

  // Low 2W bits of the product of sign-extended operands are the exact signed product.
  assign w_prod_u = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
  assign w_prod_s = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q} *
                    {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q};

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // Requester 1 wins when alone, or when both ask and it holds priority.
    w_win1  = REQ1 & (~REQ0 | pri_q);
    case (state_q)
      ST_IDLE: begin
        if (REQ0 | REQ1) begin
          owner_d = w_win1;
          a_d     = w_win1 ? A1 : A0;
          b_d     = w_win1 ? B1 : B0;
          sgn_d   = w_win1 ? SIGNED1 : SIGNED0;
          cnt_d   = C_CNT_LOAD;
          pri_d   = ~w_win1;
          gnt0_d  = ~w_win1;
          gnt1_d  = w_win1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = sgn_q ? w_prod_s : w_prod_u;
          done0_d      = ~owner_q;
          done1_d      = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pri_q   <= 1'b0;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign BUSY  = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_sched
// Purpose : Directed, table-driven self-checking bench for mult_sched.
// Revision: 1.0
// ============================================================================
module tb_mult_sched;

  localparam int W      = 32;
  localparam int SETTLE = 2;

  logic         CLK, RST;
  logic         REQ0, SIGNED0, REQ1, SIGNED1;
  logic [W-1:0] A0, B0, A1, B1;
  logic         GNT0, GNT1, DONE0, DONE1, BUSY;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int passes = 0;

  mult_sched #(.DATA_WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .SIGNED0(SIGNED0), .A0(A0), .B0(B0),
    .REQ1(REQ1), .SIGNED1(SIGNED1), .A1(A1), .B1(B1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .HI(HI), .LO(LO), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         who;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Drives one single-requester op at a negedge and checks every cycle until DONE.
  task automatic do_op(input logic who, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [63:0] exp, input string tag);
    if (who) begin REQ1 = 1'b1; SIGNED1 = sgn; A1 = a; B1 = b; end
    else     begin REQ0 = 1'b1; SIGNED0 = sgn; A0 = a; B0 = b; end
    @(negedge CLK);
    chk({tag, " gnt"}, {62'd0, GNT1, GNT0}, who ? 64'd2 : 64'd1);
    chk({tag, " busy@gnt"}, {63'd0, BUSY}, 64'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    for (int i = 1; i < SETTLE; i++) begin
      @(negedge CLK);
      chk({tag, " early done"}, {62'd0, DONE1, DONE0}, 64'd0);
      chk({tag, " busy run"}, {63'd0, BUSY}, 64'd1);
    end
    @(negedge CLK);
    chk({tag, " done"}, {62'd0, DONE1, DONE0}, who ? 64'd2 : 64'd1);
    chk({tag, " busy@done"}, {63'd0, BUSY}, 64'd0);
    chk({tag, " hilo"}, {HI, LO}, exp);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'd10,        32'd20,        64'h00000000_000000C8};
    vecs[1] = '{1'b1, 1'b0, 32'h90000000,  32'h70000000,  64'h3F000000_00000000};
    vecs[2] = '{1'b0, 1'b1, 32'h90000000,  32'h70000000,  64'hCF000000_00000000};
    vecs[3] = '{1'b1, 1'b1, 32'h70000000,  32'h70000000,  64'h31000000_00000000};
    vecs[4] = '{1'b0, 1'b0, 32'h70000000,  32'h70000000,  64'h31000000_00000000};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    vecs[6] = '{1'b0, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001};
    vecs[7] = '{1'b1, 1'b1, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
    vecs[8] = '{1'b0, 1'b1, 32'h80000000,  32'h00000001,  64'hFFFFFFFF_80000000};
    vecs[9] = '{1'b1, 1'b0, 32'h00000000,  32'h12345678,  64'h00000000_00000000};

    RST = 1'b0;
    REQ0 = 1'b0; SIGNED0 = 1'b0; A0 = '0; B0 = '0;
    REQ1 = 1'b0; SIGNED1 = 1'b0; A1 = '0; B1 = '0;

    // Reset state, then idle with no requests.
    repeat (3) @(negedge CLK);
    chk("reset outs", {59'd0, GNT0, GNT1, DONE0, DONE1, BUSY}, 64'd0);
    chk("reset hilo", {HI, LO}, 64'd0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle outs", {59'd0, GNT0, GNT1, DONE0, DONE1, BUSY}, 64'd0);
    chk("idle hilo", {HI, LO}, 64'd0);

    // Simultaneous signed requests: 0 first (PRI=0), 1 three cycles later.
    REQ0 = 1'b1; SIGNED0 = 1'b1; A0 = 32'hFFFFFFFD; B0 = 32'hFFFFFFF1;
    REQ1 = 1'b1; SIGNED1 = 1'b1; A1 = 32'h90000000; B1 = 32'h70000000;
    @(negedge CLK);
    chk("sim gnt0", {62'd0, GNT1, GNT0}, 64'd1);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("sim mid", {62'd0, DONE1, DONE0}, 64'd0);
    @(negedge CLK);
    chk("sim done0", {62'd0, DONE1, DONE0}, 64'd1);
    chk("sim hilo0", {HI, LO}, 64'h00000000_0000002D);
    chk("sim no gnt1 yet", {62'd0, GNT1, GNT0}, 64'd0);
    @(negedge CLK);
    chk("sim gnt1", {62'd0, GNT1, GNT0}, 64'd2);
    REQ1 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("sim done1", {62'd0, DONE1, DONE0}, 64'd2);
    chk("sim hilo1", {HI, LO}, 64'hCF000000_00000000);

    // Table of single-requester operations, issued back to back.
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].who, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
            $sformatf("vec%0d", i));

    repeat (4) @(negedge CLK);
    chk("hold hilo", {HI, LO}, vecs[9].exp);
    do_op(1'b0, 1'b0, 32'd7, 32'd9, 64'd63, "pre-reset");

    // Reset during RUN discards the op; PRI returns to 0.
    REQ0 = 1'b1; SIGNED0 = 1'b0; A0 = 32'd100; B0 = 32'd100;
    @(negedge CLK);
    chk("mid gnt0", {62'd0, GNT1, GNT0}, 64'd1);
    REQ0 = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("mid busy", {63'd0, BUSY}, 64'd0);
    chk("mid hilo", {HI, LO}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 1) RST = 1'b1;
      chk("mid no done", {62'd0, DONE1, DONE0}, 64'd0);
    end
    do_op(1'b1, 1'b0, 32'd3, 32'd15, 64'h2D, "post-reset");

    // Fairness under continuous requests from both sides.
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    REQ0 = 1'b1; SIGNED0 = 1'b0; A0 = 32'd2; B0 = 32'd3;
    REQ1 = 1'b1; SIGNED1 = 1'b1; A1 = 32'd5; B1 = 32'hFFFFFFF9;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] eg, ed;
      logic       own;
      @(negedge CLK);
      own = ((k / 3) % 2) == 1;
      eg  = (k % 3 == 0) ? (own ? 2'b10 : 2'b01) : 2'b00;
      ed  = (k % 3 == 2) ? (own ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("fair gnt k%0d", k), {62'd0, GNT1, GNT0}, {62'd0, eg});
      chk($sformatf("fair done k%0d", k), {62'd0, DONE1, DONE0}, {62'd0, ed});
      if (k % 3 == 2)
        chk($sformatf("fair hilo k%0d", k), {HI, LO},
            own ? 64'hFFFFFFFF_FFFFFFDD : 64'd6);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
